srl_fifo: RTL and testbench

SRL_FIFO -- requirements
Module: srl_fifo

---
 rtl/srl_fifo.sv | 84 ++++++++
 tb/tb_srl_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo.sv
// Shift-register FIFO: writes shift in at entry 0, the head sits at entry COUNT-1.
// Optional registered output stage; storage is reset-free so it maps onto SRLs.
module srl_fifo #(
  parameter int       WIDTH    = 8,
  parameter int       DEPTH    = 32,
  parameter int       AF_LEVEL = 30,
  parameter bit       OUT_REG  = 1'b0,
  parameter bit       CE_1     = 1'b0,
  localparam int      CW       = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] DIN,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DOUT_VALID,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ALMOST_FULL,
  output logic [CW-1:0]    COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [WIDTH-1:0]            head;
  logic                        en, rd_acc, wr_acc;

  assign en     = CE_1 ? 1'b1 : CE;
  assign rd_acc = en & RD_EN & ~EMPTY;
  assign wr_acc = en & WR_EN & (~FULL | rd_acc);

  assign EMPTY       = (COUNT == '0);
  assign FULL        = (COUNT == CW'(DEPTH));
  assign ALMOST_FULL = (COUNT >= CW'(AF_LEVEL));

  // No reset on storage; the reset cycle only blocks the shift.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem <= {mem[DEPTH-2:0], DIN};
  end

  always_comb begin
    head = '0;
    for (int i = 0; i < DEPTH; i++)
      if (COUNT == CW'(i+1)) head = mem[i];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      COUNT     <= '0;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= en & WR_EN & FULL & ~rd_acc;
      UNDERFLOW <= en & RD_EN & EMPTY;
      if (wr_acc && !rd_acc)      COUNT <= COUNT + 1'b1;
      else if (rd_acc && !wr_acc) COUNT <= COUNT - 1'b1;
    end
  end

  generate
    if (OUT_REG) begin : g_oreg
      logic [WIDTH-1:0] dout_q;
      logic             vld_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else if (en) begin
          vld_q <= rd_acc;
          if (rd_acc) dout_q <= head;
        end
      end
      assign DOUT       = dout_q;
      assign DOUT_VALID = vld_q;
    end else begin : g_fwft
      assign DOUT       = head;
      assign DOUT_VALID = ~EMPTY;
    end
  endgenerate

endmodule

// File: tb/tb_srl_fifo.sv
// Directed bench: default FWFT FIFO plus a 16x5 registered-output instance.
module tb_srl_fifo;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;
  // instance 0: defaults
  logic       ce0, we0, re0;
  logic [7:0] din0, dout0;
  logic       dv0, emp0, ful0, af0, ovf0, unf0;
  logic [5:0] cnt0;
  // instance 1: WIDTH 16, DEPTH 5, AF 4, registered output
  logic        ce1, we1, re1;
  logic [15:0] din1, dout1;
  logic        dv1, emp1, ful1, af1, ovf1, unf1;
  logic [2:0]  cnt1;

  int n_cmp = 0, n_err = 0;

  srl_fifo u0 (
    .CLK(CLK), .RST(RST), .CE(ce0), .WR_EN(we0), .DIN(din0), .RD_EN(re0),
    .DOUT(dout0), .DOUT_VALID(dv0), .EMPTY(emp0), .FULL(ful0),
    .ALMOST_FULL(af0), .COUNT(cnt0), .OVERFLOW(ovf0), .UNDERFLOW(unf0));

  srl_fifo #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .OUT_REG(1'b1)) u1 (
    .CLK(CLK), .RST(RST), .CE(ce1), .WR_EN(we1), .DIN(din1), .RD_EN(re1),
    .DOUT(dout1), .DOUT_VALID(dv1), .EMPTY(emp1), .FULL(ful1),
    .ALMOST_FULL(af1), .COUNT(cnt1), .OVERFLOW(ovf1), .UNDERFLOW(unf1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc0(input logic w, input logic r, input logic [7:0] d);
    we0 = w; re0 = r; din0 = d;
    @(posedge CLK); #1;
  endtask

  task automatic cyc1(input logic w, input logic r, input logic [15:0] d);
    we1 = w; re1 = r; din1 = d;
    @(posedge CLK); #1;
  endtask

  logic [7:0] exp8;

  initial begin
    RST = 1'b1;
    ce0 = 1'b1; we0 = 1'b1; re0 = 1'b1; din0 = 8'hFF;
    ce1 = 1'b1; we1 = 1'b1; re1 = 1'b1; din1 = 16'hFFFF;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("rst_cnt",   cnt0, 0);
    chk("rst_empty", emp0, 1);
    chk("rst_full",  ful0, 0);
    chk("rst_af",    af0,  0);
    chk("rst_ovf",   ovf0, 0);
    chk("rst_unf",   unf0, 0);
    chk("rst_dout",  dout0, 0);
    chk("rst_dv",    dv0,  0);
    chk("rst_dout1", dout1, 0);
    chk("rst_dv1",   dv1,  0);
    RST = 1'b0;
    we1 = 1'b0; re1 = 1'b0;

    // fill 0x01..0x20
    for (int i = 1; i <= 32; i++) begin
      cyc0(1, 0, 8'(i));
      chk("fill_cnt", cnt0, i);
      chk("fill_af",  af0,  (i >= 30));
      chk("fill_full", ful0, (i == 32));
    end
    chk("fill_head", dout0, 8'h01);
    chk("fill_dv",   dv0,   1);

    // overflow on full
    cyc0(1, 0, 8'h77);
    chk("ovf_pulse", ovf0, 1);
    chk("ovf_cnt",   cnt0, 32);
    cyc0(0, 0, 8'h00);
    chk("ovf_clear", ovf0, 0);
    chk("ovf_head",  dout0, 8'h01);

    // simultaneous read+write on full
    cyc0(1, 1, 8'hAA);
    chk("rw_full_cnt", cnt0, 32);
    chk("rw_full_ovf", ovf0, 0);

    // drain: 0x02..0x20 then 0xAA
    for (int i = 0; i < 32; i++) begin
      exp8 = (i < 31) ? 8'(i + 2) : 8'hAA;
      chk("drain_dout", dout0, exp8);
      cyc0(0, 1, 8'h00);
    end
    chk("drain_empty", emp0, 1);
    chk("drain_cnt",   cnt0, 0);
    chk("drain_dout0", dout0, 0);
    chk("drain_dv",    dv0,  0);

    // write+read on empty
    cyc0(1, 1, 8'h55);
    chk("we_empty_unf",  unf0, 1);
    chk("we_empty_cnt",  cnt0, 1);
    chk("we_empty_dout", dout0, 8'h55);
    cyc0(0, 0, 8'h00);
    chk("unf_clear", unf0, 0);

    // CE low freezes everything
    ce0 = 1'b0;
    cyc0(1, 1, 8'h99);
    chk("ce0_cnt",  cnt0, 1);
    chk("ce0_dout", dout0, 8'h55);
    ce0 = 1'b1;
    cyc0(0, 1, 8'h00);
    chk("ce0_drain", emp0, 1);
    cyc0(0, 1, 8'h00);
    chk("unf_read", unf0, 1);

    // reset mid-burst
    for (int i = 0; i < 10; i++) cyc0(1, 0, 8'(8'h10 + i));
    chk("burst_cnt", cnt0, 10);
    RST = 1'b1;
    cyc0(1, 0, 8'hEE);
    chk("mrst_cnt",   cnt0, 0);
    chk("mrst_empty", emp0, 1);
    RST = 1'b0;
    cyc0(1, 0, 8'h3C);
    chk("post_rst_cnt",  cnt0, 1);
    chk("post_rst_dout", dout0, 8'h3C);
    cyc0(0, 1, 8'h00);
    chk("post_rst_empty", emp1 & emp0, 1);

    // registered-output instance (reset above also cleared it)
    we0 = 1'b0; re0 = 1'b0;
    cyc1(1, 0, 16'h1234);
    chk("r1_cnt",  cnt1, 1);
    chk("r1_dv0",  dv1,  0);
    chk("r1_dout0", dout1, 0);
    cyc1(0, 1, 16'h0000);
    chk("r1_dout", dout1, 16'h1234);
    chk("r1_dv",   dv1,  1);
    chk("r1_empty", emp1, 1);
    cyc1(0, 0, 16'h0000);
    chk("r1_dv_drop", dv1, 0);
    chk("r1_hold",    dout1, 16'h1234);

    cyc1(1, 0, 16'hBEEF);
    cyc1(1, 0, 16'hCAFE);
    cyc1(0, 1, 16'h0000);
    chk("r1_rd_beef", dout1, 16'hBEEF);
    chk("r1_cnt1",    cnt1, 1);
    ce1 = 1'b0;
    cyc1(1, 1, 16'h5A5A);
    chk("r1_ce_cnt",  cnt1, 1);
    chk("r1_ce_dout", dout1, 16'hBEEF);
    chk("r1_ce_dv",   dv1, 1);
    ce1 = 1'b1;
    cyc1(0, 1, 16'h0000);
    chk("r1_rd_cafe", dout1, 16'hCAFE);
    chk("r1_dv2",     dv1, 1);
    cyc1(0, 1, 16'h0000);
    chk("r1_unf",      unf1, 1);
    chk("r1_unf_dv",   dv1,  0);
    chk("r1_unf_hold", dout1, 16'hCAFE);

    for (int i = 1; i <= 5; i++) begin
      cyc1(1, 0, 16'(16'h0100 + i));
      chk("r1_fill_af",   af1,  (i >= 4));
      chk("r1_fill_full", ful1, (i == 5));
    end
    cyc1(1, 0, 16'hDEAD);
    chk("r1_ovf", ovf1, 1);
    chk("r1_ovf_cnt", cnt1, 5);
    cyc1(0, 1, 16'h0000);
    chk("r1_first", dout1, 16'h0101);
    chk("r1_ovf_clr", ovf1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
